// File: rtl/fetch_stall_ctrl.sv
// Stall and bubble scheduler for the 5-stage MIPS pipeline: Tuse/Tnew data hazards
// plus a busy countdown for the multi-cycle mult/div unit.
module fetch_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_wa,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        stall,
    output logic        e_bubble,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        h_rs, h_rt, h_md;

    // A register that is written by nothing (wa=0) or is $0 can never hazard;
    // Tuse=3 marks an unused operand and is never below any Tnew.
    always_comb begin
        h_rs = (d_rs != 5'd0) &&
               (((d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
                ((d_rs == m_wa) && (d_tuse_rs < m_tnew)));
        h_rt = (d_rt != 5'd0) &&
               (((d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
                ((d_rt == m_wa) && (d_tuse_rt < m_tnew)));
        h_md = d_is_md && (e_md_start || md_busy);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A start while busy reloads the counter, so the newest op sets the busy window.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_md_start)
            md_cnt_d = e_md_div ? DIV_CNT : MULT_CNT;
        else if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_comb begin
        md_busy   = (md_cnt_q != 4'd0);
        stall     = h_rs | h_rt | h_md;
        e_bubble  = stall;
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Vector-table and sequence bench for fetch_stall_ctrl with an expected-result queue.
module tb_fetch_stall_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  d_rs, d_rt, e_wa, m_wa;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_is_md, e_md_start, e_md_div;
    logic        stall, e_bubble, md_busy;
    logic [31:0] stall_cnt;

    fetch_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .clr(clr), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
        .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
        .e_md_start(e_md_start), .e_md_div(e_md_div),
        .stall(stall), .e_bubble(e_bubble), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic [4:0] rs, rt;
        logic [1:0] tuse_rs, tuse_rt;
        logic       is_md;
        logic [4:0] e_wa;
        logic [1:0] e_tnew;
        logic [4:0] m_wa;
        logic [1:0] m_tnew;
        logic       start, div;
        logic       exp_stall, exp_busy;
    } vec_t;

    typedef struct {
        logic        stall, busy;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[10];
    logic [31:0] exp_cnt = 32'd0;
    int          n_chk = 0, n_fail = 0;

    function automatic vec_t mk(logic c, logic [4:0] rs, logic [1:0] tr, logic [4:0] rt,
                                logic [1:0] tt, logic md, logic [4:0] ew, logic [1:0] et,
                                logic [4:0] mw, logic [1:0] mt, logic st, logic dv,
                                logic es, logic eb);
        vec_t v;
        v.clr = c; v.rs = rs; v.tuse_rs = tr; v.rt = rt; v.tuse_rt = tt; v.is_md = md;
        v.e_wa = ew; v.e_tnew = et; v.m_wa = mw; v.m_tnew = mt; v.start = st; v.div = dv;
        v.exp_stall = es; v.exp_busy = eb;
        return v;
    endfunction

    // Idle D instruction (both operands unused) with optional md controls.
    function automatic vec_t md_vec(logic c, logic md, logic st, logic dv, logic es, logic eb);
        return mk(c, 5'd0, 2'd3, 5'd0, 2'd3, md, 5'd0, 2'd0, 5'd0, 2'd0, st, dv, es, eb);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        clr = v.clr; d_rs = v.rs; d_rt = v.rt; d_tuse_rs = v.tuse_rs; d_tuse_rt = v.tuse_rt;
        d_is_md = v.is_md; e_wa = v.e_wa; e_tnew = v.e_tnew; m_wa = v.m_wa; m_tnew = v.m_tnew;
        e_md_start = v.start; e_md_div = v.div;
        sb.push_back('{v.exp_stall, v.exp_busy, exp_cnt, name});
        #1;
        e = sb.pop_front();
        check({e.name, ".stall"},     32'(stall),    32'(e.stall));
        check({e.name, ".e_bubble"},  32'(e_bubble), 32'(e.stall));
        check({e.name, ".md_busy"},   32'(md_busy),  32'(e.busy));
        check({e.name, ".stall_cnt"}, stall_cnt,     e.cnt);
        if (v.clr) exp_cnt = 32'd0;
        else if (v.exp_stall) exp_cnt = exp_cnt + 32'd1;
    endtask

    initial begin
        // Data-hazard vectors: clr rs tuse_rs rt tuse_rt md e_wa e_tnew m_wa m_tnew st dv | stall busy
        tbl[0] = mk(0, 5'd8, 2'd1, 5'd0, 2'd3, 0, 5'd8, 2'd2, 5'd0, 2'd0, 0, 0, 1, 0); // load-use
        tbl[1] = mk(0, 5'd8, 2'd1, 5'd0, 2'd3, 0, 5'd0, 2'd0, 5'd8, 2'd1, 0, 0, 0, 0); // lw in M
        tbl[2] = mk(0, 5'd0, 2'd0, 5'd0, 2'd3, 0, 5'd0, 2'd2, 5'd0, 2'd0, 0, 0, 0, 0); // $0
        tbl[3] = mk(0, 5'd0, 2'd3, 5'd9, 2'd3, 0, 5'd9, 2'd2, 5'd0, 2'd0, 0, 0, 0, 0); // rt unused
        tbl[4] = mk(0, 5'd0, 2'd3, 5'd9, 2'd1, 0, 5'd9, 2'd2, 5'd0, 2'd0, 0, 0, 1, 0); // rt hazard
        tbl[5] = mk(0, 5'd5, 2'd0, 5'd0, 2'd3, 0, 5'd0, 2'd0, 5'd5, 2'd1, 0, 0, 1, 0); // M hazard
        tbl[6] = mk(0, 5'd5, 2'd1, 5'd0, 2'd3, 0, 5'd5, 2'd1, 5'd0, 2'd0, 0, 0, 0, 0); // tuse==tnew
        tbl[7] = mk(0, 5'd0, 2'd3, 5'd7, 2'd2, 0, 5'd7, 2'd2, 5'd0, 2'd0, 0, 0, 0, 0); // rt tuse==2
        tbl[8] = mk(0, 5'd3, 2'd0, 5'd0, 2'd3, 0, 5'd4, 2'd2, 5'd4, 2'd1, 0, 0, 0, 0); // no match
        tbl[9] = md_vec(0, 1, 0, 0, 0, 0);                                           // md idle

        clr = 1'b1; d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 1'b0;
        e_wa = '0; e_tnew = '0; m_wa = '0; m_tnew = '0; e_md_start = 1'b0; e_md_div = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Mult with a HI/LO reader held in D.
        step(md_vec(0, 1, 1, 0, 1, 0), "mult0");
        for (int c = 1; c <= 5; c++) step(md_vec(0, 1, 0, 0, 1, 1), $sformatf("mult%0d", c));
        step(md_vec(0, 1, 0, 0, 0, 0), "mult6");

        // Div with non-md D instructions, one md reader mid-way.
        step(md_vec(0, 0, 1, 1, 0, 0), "div0");
        for (int c = 1; c <= 10; c++)
            step(md_vec(0, c == 5, 0, 0, c == 5, 1), $sformatf("div%0d", c));
        step(md_vec(0, 1, 0, 0, 0, 0), "div11");

        // Reset in the middle of a div, then reset colliding with a start.
        step(md_vec(0, 0, 1, 1, 0, 0), "rdiv0");
        for (int c = 1; c <= 3; c++) step(md_vec(0, 1, 0, 0, 1, 1), $sformatf("rdiv%0d", c));
        step(md_vec(1, 0, 0, 0, 0, 1), "rdiv4_clr");
        step(md_vec(0, 1, 0, 0, 0, 0), "rdiv5");
        step(md_vec(1, 0, 1, 0, 0, 0), "clr_start");
        step(md_vec(0, 1, 0, 0, 0, 0), "clr_start_after");

        // Div restarts a mult on its second busy cycle.
        step(md_vec(0, 0, 1, 0, 0, 0), "rst0");
        step(md_vec(0, 0, 0, 0, 0, 1), "rst1");
        step(md_vec(0, 0, 1, 1, 0, 1), "rst2");
        for (int c = 3; c <= 12; c++) step(md_vec(0, 0, 0, 0, 0, 1), $sformatf("rst%0d", c));
        step(md_vec(0, 0, 0, 0, 0, 0), "rst13");

        // Performance counter wrap.
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        step(tbl[0], "wrap_stall");
        step(tbl[2], "wrap_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stall_ctrl.md
Name: fetch_stall_ctrl

Overview:
- Hazard and stall scheduler for the 5-stage MIPS pipeline.
- Decides each cycle whether the fetch unit and the IF/ID register hold (stall), and whether a bubble is injected into ID/EX.
- Compares D-stage register use-time against E/M-stage result-ready time (Tuse/Tnew).
- Sequences the multi-cycle mult/div unit with a busy countdown, stalling HI/LO-related instructions until it is free.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset.
- d_rs  input  5  rs field of the instruction in D.
- d_rt  input  5  rt field of the instruction in D.
- d_tuse_rs  input  2  cycles until D needs rs (0, 1 or 2); 3 = rs unused.
- d_tuse_rt  input  2  same for rt.
- d_is_md  input  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- e_wa  input  5  destination register of the E instruction; 0 = none.
- e_tnew  input  2  cycles until the E result is forwardable (0..2).
- m_wa  input  5  destination register of the M instruction; 0 = none.
- m_tnew  input  2  cycles until the M result is forwardable (0..1).
- e_md_start  input  1  E instruction is mult/div this cycle (single-cycle pulse).
- e_md_div  input  1  qualifies e_md_start: 1 = div/divu, 0 = mult/multu.
- stall  output  1  hold PC and IF/ID; drives the fetch unit's stall input.
- e_bubble  output  1  clear ID/EX this cycle (insert nop).
- md_busy  output  1  mult/div unit is computing.
- stall_cnt  output  32  count of stalled cycles since reset (performance counter).

Behaviour:
- Reset: on a rising edge with clr=1: md counter=0, md_busy=0, stall_cnt=0. clr takes priority over e_md_start in the same cycle.
- stall and e_bubble are combinational. During the clr cycle they follow their inputs; immediately after reset md_busy=0, so only data hazards can stall.
- rs hazard, h_rs = (d_rs!=0) && ((d_rs==e_wa && d_tuse_rs<e_tnew) || (d_rs==m_wa && d_tuse_rs<m_tnew)).
  - d_tuse_rs=3 never hazards.
  - A match with wa=0 never hazards.
  - Compare widths: 2-bit unsigned.
- rt hazard, h_rt: same rule with d_rt and d_tuse_rt.
- md hazard: h_md = d_is_md && (e_md_start || md_busy).
- stall = h_rs | h_rt | h_md; e_bubble = stall (always equal).
- When stall=1 the fetch unit holds PC and ignores any branch redirect that cycle. The redirect is re-presented once D advances.
- md counter state machine, 4-bit down-counter:
  - IDLE (cnt=0): on e_md_start, load cnt = e_md_div ? DIV_CYCLES : MULT_CYCLES; go to BUSY.
  - BUSY (cnt>0): decrement by 1 each cycle. md_busy=1 exactly when cnt!=0 (registered).
  - Result: after a mult start at edge T, md_busy is high for edges T+1..T+5 (cycles) and low from T+5's update onward, i.e. 5 cycles high.
  - e_md_start while BUSY: reload with the new op's count (restart). The pipeline cannot normally produce this; the bench still checks it.
- stall_cnt: +1 on each rising edge where stall=1 and clr=0; wraps 0xFFFFFFFF -> 0.
- No other state. Identical inputs in consecutive cycles give identical stall except through md_busy.

Test Plan:
- Load-use: E=lw, e_wa=8, e_tnew=2; D=addu, d_rs=8, d_tuse_rs=1 -> stall=1, e_bubble=1.
  - Next cycle M: m_wa=8, m_tnew=1, e_wa=0 -> stall=0.
  - stall_cnt=1.
- $0 and unused operand:
  - d_rs=0=e_wa, e_tnew=2, d_tuse_rs=0 -> stall=0.
  - d_rt=9=e_wa, d_tuse_rt=3 -> stall=0.
- Mult: pulse e_md_start=1, e_md_div=0 at cycle 0 -> md_busy=1 for cycles 1..5, 0 at cycle 6.
  - d_is_md=1 held throughout -> stall=1 cycles 0..5, 0 at cycle 6.
- Div: same with e_md_div=1 -> md_busy high exactly 10 cycles. A non-md D instruction during busy -> stall=0.
- Reset mid-div: assert clr at busy cycle 4 -> next cycle md_busy=0, stall_cnt=0, d_is_md=1 no longer stalls. clr together with e_md_start -> md_busy stays 0.
- Restart/wrap: e_md_start(div) at busy cycle 2 of a mult -> 10 further busy cycles. Force stall_cnt to 0xFFFFFFFF then one stall -> 0.
